nibble_serial_subtractor: RTL and testbench



---
 rtl/nibble_serial_subtractor_pkg.sv | 17 +
 rtl/nibble_serial_subtractor_sub_slice4.sv | 30 +++
 rtl/nibble_serial_subtractor.sv | 120 ++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared constants, FSM state type and sizing helper for the nibble-serial subtractor.
package nibble_serial_subtractor_pkg;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width needed to count from 0 to nslice inclusive.
  function automatic int unsigned skip_width(input int unsigned nslice);
    return $clog2(nslice + 1);
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_sub_slice4.sv
// Combinational 4-bit adder slice with a carry-skip bypass when every bit propagates.
module sub_slice4
  import nibble_serial_subtractor_pkg::*;
(
  input  logic [NIBBLE-1:0] a4,
  input  logic [NIBBLE-1:0] b4,
  input  logic              cin,
  output logic [NIBBLE-1:0] sum4,
  output logic              cout,
  output logic              prop_all
);

  logic [NIBBLE-1:0] prop;
  logic [NIBBLE:0]   carry;

  always_comb begin
    prop     = a4 ^ b4;
    carry    = '0;
    carry[0] = cin;
    sum4     = '0;
    for (int unsigned i = 0; i < NIBBLE; i++) begin
      sum4[i]    = prop[i] ^ carry[i];
      carry[i+1] = (a4[i] & b4[i]) | (prop[i] & carry[i]);
    end
    prop_all = &prop;
    // All-propagate means the ripple carry-out equals cin, so the bypass is exact.
    cout     = prop_all ? cin : carry[NIBBLE];
  end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle a - b - bin, one 4-bit slice per clock (LS nibble first), with valid/ready on both sides.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [WIDTH-1:0]                          a,
  input  logic [WIDTH-1:0]                          b,
  input  logic                                      bin,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [WIDTH-1:0]                          diff,
  output logic                                      bout,
  output logic                                      overflow,
  output logic                                      zero,
  output logic [skip_width(WIDTH/NIBBLE)-1:0]       skip_count
);

  localparam int unsigned NSLICE = WIDTH / NIBBLE;
  localparam int unsigned SKW    = skip_width(NSLICE);
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              carry;
  logic [IDXW-1:0]   idx;

  logic [NIBBLE-1:0] a4;
  logic [NIBBLE-1:0] b4;
  logic [NIBBLE-1:0] sum4;
  logic              cout;
  logic              prop_all;
  logic [WIDTH-1:0]  next_diff;
  logic              last_slice;

  always_comb begin
    a4         = a_q[idx*NIBBLE +: NIBBLE];
    b4         = ~b_q[idx*NIBBLE +: NIBBLE];
    next_diff  = diff;
    next_diff[idx*NIBBLE +: NIBBLE] = sum4;
    last_slice = (idx == IDXW'(NSLICE - 1));
  end

  sub_slice4 u_slice (
    .a4       (a4),
    .b4       (b4),
    .cin      (carry),
    .sum4     (sum4),
    .cout     (cout),
    .prop_all (prop_all)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      diff       <= '0;
      bout       <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
      skip_count <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry      <= 1'b0;
      idx        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            carry      <= ~bin;
            idx        <= '0;
            skip_count <= '0;
            in_ready   <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          diff  <= next_diff;
          carry <= cout;
          if (prop_all) skip_count <= skip_count + SKW'(1);
          if (last_slice) begin
            // Flags are taken from the completed result so they are valid together with out_valid.
            bout      <= ~cout;
            overflow  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) & (next_diff[WIDTH-1] != a_q[WIDTH-1]);
            zero      <= (next_diff == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Randomized self-checking bench for nibble_serial_subtractor (WIDTH=16) against an arithmetic reference.
module tb_nibble_serial_subtractor;

  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          bin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  diff;
  logic          bout;
  logic          overflow;
  logic          zero;
  logic [2:0]    skip_count;

  int checks = 0;
  int errors = 0;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .bout       (bout),
    .overflow   (overflow),
    .zero       (zero),
    .skip_count (skip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; a slice skips exactly when the a and b nibbles match.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] ediff, output logic ebout, output logic eov,
                       output logic ezero, output logic [2:0] eskip);
    int r, sr;
    int n;
    r     = int'(ma) - int'(mb) - int'(mbin);
    ediff = W'(r);
    ebout = (r < 0);
    sr    = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    eov   = (sr < -32768) || (sr > 32767);
    ezero = (ediff == 0);
    n = 0;
    for (int i = 0; i < NSLICE; i++)
      if (((ma >> (4*i)) & 16'hF) == ((mb >> (4*i)) & 16'hF)) n++;
    eskip = 3'(n);
  endtask

  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                        input int hold);
    logic [W-1:0] ediff;
    logic ebout, eov, ezero;
    logic [2:0] eskip;
    int lat;
    bit seen;
    model(oa, ob, obin, ediff, ebout, eov, ezero, eskip);
    @(negedge clk);
    a = oa; b = ob; bin = obin; in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    check("in_ready_run", in_ready, 0);
    lat = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin seen = 1; break; end
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, NSLICE);
    check("diff", diff, ediff);
    check("bout", bout, ebout);
    check("overflow", overflow, eov);
    check("zero", zero, ezero);
    check("skip_count", skip_count, eskip);
    in_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_diff", diff, ediff);
      check("hold_flags", {bout, overflow, zero, skip_count}, {ebout, eov, ezero, eskip});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_outputs", {out_valid, diff, bout, overflow, zero, skip_count}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0234, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 0);
    run_op(16'h5A5A, 16'h5A5A, 1'b0, 0);
    run_op(16'h5A5A, 16'h5A5A, 1'b1, 0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 5);
    run_op(16'h0010, 16'h0001, 1'b1, 0);

    // Reset while slice 2 is being processed discards the operation.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h1234; bin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_outputs", {out_valid, diff, bout, overflow, zero, skip_count}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0003, 16'h0001, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra ^ W'(16'hF << (4 * $urandom_range(0, 3))) : W'($urandom);
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
